// File: rtl/video_ram_write_arbiter_pkg.sv
// Shared constants and types for the video RAM write path.
package video_ram_write_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StClear = 2'd2
    } arb_state_e;

    localparam int unsigned FifoDepth      = 4;
    localparam int unsigned FifoPtrWidth   = $clog2(FifoDepth);
    localparam int unsigned FifoCountWidth = FifoPtrWidth + 1;

endpackage

// File: rtl/video_write_fifo.sv
// Four-entry {address, data} CPU write buffer with single-cycle push and pop.
module video_write_fifo
    import video_ram_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  ready,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [ADDR_WIDTH-1:0]     addr_mem [FifoDepth];
    logic [DATA_WIDTH-1:0]     data_mem [FifoDepth];
    logic [FifoPtrWidth-1:0]   wr_ptr_q;
    logic [FifoPtrWidth-1:0]   rd_ptr_q;
    logic [FifoCountWidth-1:0] count_q;
    logic                      do_push;
    logic                      do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop && !empty;
    // A same-cycle pop frees a slot, so a full buffer can still take a write.
    assign ready   = (count_q != FifoCountWidth'(FifoDepth)) || do_pop;
    assign do_push = push && ready;

    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + FifoPtrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FifoPtrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + FifoCountWidth'(1);
                2'b01:   count_q <= count_q - FifoCountWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/video_ram_write_arbiter.sv
// Arbitrates buffered CPU writes and clear-screen sweeps onto the video RAM write port.
module video_ram_write_arbiter
    import video_ram_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCpuWrite,
    input  logic [ADDR_WIDTH-1:0] iCpuAddress,
    input  logic [DATA_WIDTH-1:0] iCpuData,
    output logic                  oCpuReady,
    input  logic                  iClear,
    input  logic [DATA_WIDTH-1:0] iClearColor,
    output logic                  oBusy,
    output logic                  oClearDone,
    output logic                  oRamWriteEnable,
    output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
    output logic [DATA_WIDTH-1:0] oRamDataIn
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_SIZE);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q;

    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] fifo_addr;
    logic [DATA_WIDTH-1:0] fifo_data;

    video_write_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (iCpuWrite),
        .push_addr (iCpuAddress),
        .push_data (iCpuData),
        .pop       (fifo_pop),
        .ready     (oCpuReady),
        .empty     (fifo_empty),
        .head_addr (fifo_addr),
        .head_data (fifo_data)
    );

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        color_d      = color_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        last_d       = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            StIdle: begin
                if (iClear) begin
                    state_d      = StClear;
                    clear_addr_d = '0;
                    color_d      = iClearColor;
                end else if (!fifo_empty) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = 1'b1;
                    addr_d   = fifo_addr;
                    data_d   = fifo_data;
                end
                // The pop above still completes when a clear arrives.
                if (iClear) begin
                    state_d      = StClear;
                    clear_addr_d = '0;
                    color_d      = iClearColor;
                end else if (fifo_empty) begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                we_d   = 1'b1;
                addr_d = clear_addr_q;
                data_d = color_q;
                if (clear_addr_q == LastAddr) begin
                    state_d = StIdle;
                    last_d  = 1'b1;
                end else begin
                    clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Busy spans the sweep's write outputs and drops together with the done pulse.
    always_comb begin
        busy_d = busy_q;
        if (state_q != StClear && state_d == StClear) begin
            busy_d = 1'b1;
        end else if (last_q) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= StIdle;
            clear_addr_q <= '0;
            color_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            color_q      <= color_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= last_q;
        end
    end

    assign oRamWriteEnable  = we_q;
    assign oRamWriteAddress = addr_q;
    assign oRamDataIn       = data_q;
    assign oBusy            = busy_q;
    assign oClearDone       = done_q;

endmodule

// File: tb/tb_video_ram_write_arbiter.sv
// Directed self-checking bench for video_ram_write_arbiter with default parameters.
module tb_video_ram_write_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned MS = 8;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iCpuWrite = 1'b0;
    logic [AW-1:0] iCpuAddress = '0;
    logic [DW-1:0] iCpuData = '0;
    logic          oCpuReady;
    logic          iClear = 1'b0;
    logic [DW-1:0] iClearColor = '0;
    logic          oBusy;
    logic          oClearDone;
    logic          oRamWriteEnable;
    logic [AW-1:0] oRamWriteAddress;
    logic [DW-1:0] oRamDataIn;

    int n_cmp = 0;
    int n_err = 0;

    video_ram_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_SIZE   (MS)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .iCpuWrite        (iCpuWrite),
        .iCpuAddress      (iCpuAddress),
        .iCpuData         (iCpuData),
        .oCpuReady        (oCpuReady),
        .iClear           (iClear),
        .iClearColor      (iClearColor),
        .oBusy            (oBusy),
        .oClearDone       (oClearDone),
        .oRamWriteEnable  (oRamWriteEnable),
        .oRamWriteAddress (oRamWriteAddress),
        .oRamDataIn       (oRamDataIn)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_write(input string tag, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (oRamWriteEnable) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_addr"}, 32'(oRamWriteAddress), 32'(ea));
            check_eq({tag, "_data"}, 32'(oRamDataIn), 32'(ed));
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (oClearDone) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_we", 32'(oRamWriteEnable), 32'd0);
        check_eq("rst_addr", 32'(oRamWriteAddress), 32'd0);
        check_eq("rst_data", 32'(oRamDataIn), 32'd0);
        check_eq("rst_ready", 32'(oCpuReady), 32'd1);
        check_eq("rst_busy", 32'(oBusy), 32'd0);
        check_eq("rst_done", 32'(oClearDone), 32'd0);
        Reset = 1'b1;
        tick();

        // Single write: accepted at edge 0, visible on the RAM port after edge 2
        iCpuWrite   = 1'b1;
        iCpuAddress = 8'h05;
        iCpuData    = 16'hABCD;
        tick();
        iCpuWrite = 1'b0;
        check_eq("single_we_e0", 32'(oRamWriteEnable), 32'd0);
        tick();
        check_eq("single_we_e1", 32'(oRamWriteEnable), 32'd0);
        tick();
        check_eq("single_we", 32'(oRamWriteEnable), 32'd1);
        check_eq("single_addr", 32'(oRamWriteAddress), 32'h05);
        check_eq("single_data", 32'(oRamDataIn), 32'hABCD);
        tick();
        check_eq("single_we_off", 32'(oRamWriteEnable), 32'd0);
        check_eq("single_addr_hold", 32'(oRamWriteAddress), 32'h05);
        check_eq("single_data_hold", 32'(oRamDataIn), 32'hABCD);
        tick();
        tick();

        // Clear sweep, with a second iClear mid-sweep that must be ignored
        iClear      = 1'b1;
        iClearColor = 16'h0F0F;
        tick();
        iClear = 1'b0;
        check_eq("sweep_busy_start", 32'(oBusy), 32'd1);
        check_eq("sweep_we_start", 32'(oRamWriteEnable), 32'd0);
        for (int i = 0; i <= int'(MS); i++) begin
            tick();
            iClear = 1'b0;
            check_eq("sweep_we", 32'(oRamWriteEnable), 32'd1);
            check_eq("sweep_addr", 32'(oRamWriteAddress), 32'(i));
            check_eq("sweep_data", 32'(oRamDataIn), 32'h0F0F);
            check_eq("sweep_busy", 32'(oBusy), 32'd1);
            check_eq("sweep_done_early", 32'(oClearDone), 32'd0);
            if (i == 3) begin
                iClear      = 1'b1;
                iClearColor = 16'h1111;
            end
        end
        tick();
        check_eq("sweep_we_end", 32'(oRamWriteEnable), 32'd0);
        check_eq("sweep_done", 32'(oClearDone), 32'd1);
        check_eq("sweep_busy_end", 32'(oBusy), 32'd0);
        tick();
        check_eq("sweep_done_pulse", 32'(oClearDone), 32'd0);
        check_eq("sweep_no_restart", 32'(oRamWriteEnable), 32'd0);
        tick();

        // FIFO full during a clear: the fifth push is refused
        iClear      = 1'b1;
        iClearColor = 16'h2222;
        tick();
        iClear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iCpuWrite   = 1'b1;
            iCpuAddress = AW'(8'h10 + k);
            iCpuData    = DW'(16'h0100 + k);
            check_eq("full_ready", 32'(oCpuReady), 32'(k < 4));
            tick();
        end
        iCpuWrite = 1'b0;
        check_eq("full_ready_after", 32'(oCpuReady), 32'd0);
        wait_done("full");
        for (int k = 0; k < 4; k++) begin
            wait_write("full_drain", AW'(8'h10 + k), DW'(16'h0100 + k));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("full_no_fifth", 32'(oRamWriteEnable), 32'd0);
        end
        check_eq("full_ready_empty", 32'(oCpuReady), 32'd1);

        // Pending entry and iClear together in IDLE: sweep goes first
        iCpuWrite   = 1'b1;
        iCpuAddress = 8'h20;
        iCpuData    = 16'h5555;
        tick();
        iCpuWrite   = 1'b0;
        iClear      = 1'b1;
        iClearColor = 16'h0A0A;
        tick();
        iClear = 1'b0;
        check_eq("simul_busy", 32'(oBusy), 32'd1);
        wait_write("simul_first", 8'h00, 16'h0A0A);
        wait_done("simul");
        wait_write("simul_entry", 8'h20, 16'h5555);
        tick();
        tick();

        // Reset in the middle of a sweep, with a buffered write to be discarded
        iClear      = 1'b1;
        iClearColor = 16'h7777;
        tick();
        iClear      = 1'b0;
        iCpuWrite   = 1'b1;
        iCpuAddress = 8'h30;
        iCpuData    = 16'hBEEF;
        tick();
        iCpuWrite = 1'b0;
        begin
            bit at3 = 1'b0;
            for (int i = 0; i < 20 && !at3; i++) begin
                if (oRamWriteEnable && oRamWriteAddress == 8'd3) at3 = 1'b1;
                else tick();
            end
            check_eq("rst_mid_reach3", 32'(at3), 32'd1);
        end
        Reset = 1'b0;
        tick();
        check_eq("rst_mid_we", 32'(oRamWriteEnable), 32'd0);
        check_eq("rst_mid_addr", 32'(oRamWriteAddress), 32'd0);
        check_eq("rst_mid_data", 32'(oRamDataIn), 32'd0);
        check_eq("rst_mid_busy", 32'(oBusy), 32'd0);
        check_eq("rst_mid_done", 32'(oClearDone), 32'd0);
        check_eq("rst_mid_ready", 32'(oCpuReady), 32'd1);
        Reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("rst_mid_no_write", 32'(oRamWriteEnable), 32'd0);
            check_eq("rst_mid_no_done", 32'(oClearDone), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_ram_write_arbiter.md
VIDEO_RAM_WRITE_ARBITER -- requirements
Module: video_ram_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the pixel/word width; it matches the video RAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the video RAM address width.
REQ-003 SHALL have parameter MEM_SIZE, default 8, meaning the highest valid address; the RAM holds MEM_SIZE+1 words.
REQ-004 SHALL have port Clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1, meaning a synchronous, active-low reset sampled on rising Clock.
REQ-006 SHALL have port iCpuWrite, input, 1, meaning the CPU write request, qualified by oCpuReady.
REQ-007 SHALL have port iCpuAddress, input, ADDR_WIDTH, meaning the CPU write address.
REQ-008 SHALL have port iCpuData, input, DATA_WIDTH, meaning the CPU write data.
REQ-009 SHALL have port oCpuReady, input/output direction output, 1, meaning the write buffer can accept an entry this cycle.
REQ-010 SHALL have port iClear, input, 1, meaning a one-cycle clear-screen command.
REQ-011 SHALL have port iClearColor, input, DATA_WIDTH, meaning the fill value, sampled when iClear is accepted.
REQ-012 SHALL have port oBusy, output, 1, meaning a clear sweep is in progress.
REQ-013 SHALL have port oClearDone, output, 1, meaning a one-cycle pulse after the last clear write.
REQ-014 SHALL have port oRamWriteEnable, output, 1, which drives the RAM iWriteEnable.
REQ-015 SHALL have port oRamWriteAddress, output, ADDR_WIDTH, which drives the RAM iWriteAddress.
REQ-016 SHALL have port oRamDataIn, output, DATA_WIDTH, which drives the RAM iDataIn.

Function
REQ-017 SHALL contain a 4-entry FIFO of {address, data}; a CPU write is accepted when iCpuWrite=1 and oCpuReady=1.
REQ-018 SHALL drive oCpuReady=1 when FIFO count<4 or when a pop occurs in the same cycle.
REQ-019 SHALL implement FSM states IDLE, DRAIN and CLEAR; all RAM write outputs are registered (1-cycle latency from the decision).
REQ-020 SHALL, in IDLE, go to CLEAR if iClear=1, else go to DRAIN if FIFO is non-empty; iClear wins a simultaneous request.
REQ-021 SHALL, in DRAIN, pop one entry per cycle and issue one RAM write per entry, return to IDLE when empty, and go to CLEAR if iClear arrives (the current pop still completes).
REQ-022 SHALL, in CLEAR, write the latched color to addresses 0..MEM_SIZE ascending at one per cycle, with no FIFO pops.
REQ-023 SHALL keep accepting CPU writes into the FIFO during CLEAR until it is full; oCpuReady=0 while full.
REQ-024 SHALL, after writing address MEM_SIZE, pulse oClearDone for 1 cycle, drop oBusy, and enter IDLE (then DRAIN if the FIFO is non-empty).
REQ-025 SHALL ignore iClear while in CLEAR, with no restart and no re-latch of the color.
REQ-026 SHALL make the clear address counter ADDR_WIDTH wide and stop at MEM_SIZE without wrapping.
REQ-027 SHALL support simultaneous push and pop with the count unchanged; FIFO pointers wrap modulo 4.
REQ-028 SHALL keep oRamWriteEnable=0 in any cycle with no write, and hold address/data at their last values.

Reset
REQ-029 SHALL, on Reset=0 at a rising edge: FSM=IDLE, FIFO emptied, oCpuReady=1, oBusy=0, oClearDone=0, oRamWriteEnable=0, oRamWriteAddress=0, oRamDataIn=0.
REQ-030 SHALL abort an in-progress CLEAR or DRAIN when reset occurs mid-operation, discard buffered writes, and not pulse oClearDone.

Structure
REQ-031 SHALL keep FSM state encodings and FIFO depth (4) as constants in the shared video package.
REQ-032 SHALL implement the FIFO as sub-module video_write_fifo; the FSM and clear counter stay in the top module.

Verification
REQ-033 SHALL cover single write: push (0x05, 0xABCD) in IDLE -> two cycles later oRamWriteEnable=1, addr 0x05, data 0xABCD for 1 cycle.
REQ-034 SHALL cover FIFO full: 5 back-to-back pushes during CLEAR -> oCpuReady=0 after the 4th, the 5th is not accepted, and the 4 entries drain in order after oClearDone.
REQ-035 SHALL cover clear sweep: iClear with color 0x0F0F, MEM_SIZE=8 -> 9 consecutive writes, addresses 0..8, then one oClearDone pulse, then oBusy=0.
REQ-036 SHALL cover simultaneous events: iClear and a pending FIFO entry in IDLE -> CLEAR first, and the entry is written after the sweep.
REQ-037 SHALL cover reset mid-clear: Reset=0 at address 3 -> next cycle all outputs are at reset values, with no further writes and no oClearDone.
REQ-038 SHALL cover repeated iClear: iClear pulsed again mid-sweep with color 0x1111 -> the sweep is unchanged and all 9 words still use 0x0F0F.
